// File: rtl/eu_speriph_plug_arbiter.sv
// eu_speriph_plug_arbiter: merges NB_PLUGS speriph slave plugs onto the
// event unit port with a hold lock, selection and an in-order owner FIFO.
// Optional: EU_PLUG_ARB_ROUND_ROBIN_EN selects round-robin, else fixed
// priority (lowest index wins).
// Ports: slv_* per-plug request in / grant + response out,
//        mst_* event-unit request out / grant + response in,
//        busy_o (owner FIFO non-empty), err_o (sticky orphan response).
module eu_speriph_plug_arbiter #(
    parameter int unsigned NB_PLUGS        = 2,
    parameter int unsigned ID_WIDTH        = 5,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NB_PLUGS-1:0]                slv_req_i,
    input  logic [NB_PLUGS-1:0][31:0]          slv_add_i,
    input  logic [NB_PLUGS-1:0]                slv_wen_i,
    input  logic [NB_PLUGS-1:0][31:0]          slv_wdata_i,
    input  logic [NB_PLUGS-1:0][3:0]           slv_be_i,
    input  logic [NB_PLUGS-1:0][ID_WIDTH-1:0]  slv_id_i,
    output logic [NB_PLUGS-1:0]                slv_gnt_o,
    output logic [NB_PLUGS-1:0]                slv_r_valid_o,
    output logic [31:0]                        slv_r_rdata_o,
    output logic                               slv_r_opc_o,
    output logic [ID_WIDTH-1:0]                slv_r_id_o,
    output logic                               mst_req_o,
    output logic [31:0]                        mst_add_o,
    output logic                               mst_wen_o,
    output logic [31:0]                        mst_wdata_o,
    output logic [3:0]                         mst_be_o,
    output logic [ID_WIDTH-1:0]                mst_id_o,
    input  logic                               mst_gnt_i,
    input  logic                               mst_r_valid_i,
    input  logic [31:0]                        mst_r_rdata_i,
    input  logic                               mst_r_opc_i,
    input  logic [ID_WIDTH-1:0]                mst_r_id_i,
    output logic                               busy_o,
    output logic                               err_o
);

    localparam int unsigned IDX_W = (NB_PLUGS > 1) ? $clog2(NB_PLUGS) : 1;
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [IDX_W-1:0] LAST_PLUG = IDX_W'(NB_PLUGS - 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(MAX_OUTSTANDING);

    logic                 lock_v_q;
    logic [IDX_W-1:0]     lock_idx_q;
    logic [IDX_W-1:0]     fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]     wr_q, rd_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q;
`ifdef EU_PLUG_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]     rr_q;
`endif

    logic [IDX_W-1:0]     sel, sel_nxt, head;
    logic                 full, lock_hit, hs, pop;

    assign full     = (cnt_q == FULL_CNT);
    assign lock_hit = lock_v_q && slv_req_i[lock_idx_q];
    assign mst_req_o = (|slv_req_i) && !full;
    assign hs       = mst_req_o && mst_gnt_i;
    assign pop      = mst_r_valid_i && (cnt_q != '0);
    assign head     = fifo_q[rd_q];
    assign sel_nxt  = (sel == LAST_PLUG) ? '0 : sel + 1'b1;

    always_comb begin
        int   j;
        logic found;
        sel   = '0;
        found = 1'b0;
        j     = 0;
        if (lock_hit) begin
            sel = lock_idx_q;
        end else begin
`ifdef EU_PLUG_ARB_ROUND_ROBIN_EN
            // scan starting at the pointer, wrapping at NB_PLUGS
            for (int i = 0; i < int'(NB_PLUGS); i++) begin
                j = int'(rr_q) + i;
                if (j >= int'(NB_PLUGS)) j = j - int'(NB_PLUGS);
                if (!found && slv_req_i[IDX_W'(j)]) begin
                    sel   = IDX_W'(j);
                    found = 1'b1;
                end
            end
`else
            for (int i = int'(NB_PLUGS) - 1; i >= 0; i--) begin
                if (slv_req_i[IDX_W'(i)]) begin
                    sel   = IDX_W'(i);
                    found = 1'b1;
                end
            end
`endif
        end
    end

    assign mst_add_o   = mst_req_o ? slv_add_i[sel]   : '0;
    assign mst_wen_o   = mst_req_o ? slv_wen_i[sel]   : 1'b0;
    assign mst_wdata_o = mst_req_o ? slv_wdata_i[sel] : '0;
    assign mst_be_o    = mst_req_o ? slv_be_i[sel]    : '0;
    assign mst_id_o    = mst_req_o ? slv_id_i[sel]    : '0;

    always_comb begin
        slv_gnt_o     = '0;
        slv_r_valid_o = '0;
        if (hs)  slv_gnt_o[sel]      = 1'b1;
        if (pop) slv_r_valid_o[head] = 1'b1;
    end

    assign slv_r_rdata_o = mst_r_rdata_i;
    assign slv_r_opc_o   = mst_r_opc_i;
    assign slv_r_id_o    = mst_r_id_i;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({hs, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_v_q   <= 1'b0;
            lock_idx_q <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) fifo_q[i] <= '0;
`ifdef EU_PLUG_ARB_ROUND_ROBIN_EN
            rr_q       <= '0;
`endif
        end else begin
            cnt_q <= cnt_d;
            if (hs) begin
                fifo_q[wr_q] <= sel;
                wr_q         <= (wr_q == LAST_PTR) ? '0 : wr_q + 1'b1;
                lock_v_q     <= 1'b0;
`ifdef EU_PLUG_ARB_ROUND_ROBIN_EN
                rr_q         <= sel_nxt;
`endif
            end else if (mst_req_o) begin
                // waiting requester keeps the port until granted
                lock_v_q   <= 1'b1;
                lock_idx_q <= sel;
            end else if (lock_v_q && !slv_req_i[lock_idx_q]) begin
                lock_v_q <= 1'b0;
            end
            if (pop) rd_q <= (rd_q == LAST_PTR) ? '0 : rd_q + 1'b1;
            if (mst_r_valid_i && cnt_q == '0) err_q <= 1'b1;
        end
    end

    assign busy_o = (cnt_q != '0);
    assign err_o  = err_q;

endmodule

// File: tb/tb_eu_speriph_plug_arbiter.sv
// Scoreboard bench for eu_speriph_plug_arbiter: stimulus pushes expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_eu_speriph_plug_arbiter;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       slv_req;
    logic [1:0][31:0] slv_add, slv_wdata;
    logic [1:0]       slv_wen;
    logic [1:0][3:0]  slv_be;
    logic [1:0][4:0]  slv_id;
    logic [1:0]       slv_gnt, slv_r_valid;
    logic [31:0]      slv_r_rdata;
    logic             slv_r_opc;
    logic [4:0]       slv_r_id;
    logic             mst_req, mst_wen, mst_gnt, mst_r_valid, mst_r_opc;
    logic [31:0]      mst_add, mst_wdata, mst_r_rdata;
    logic [3:0]       mst_be;
    logic [4:0]       mst_id, mst_r_id;
    logic             busy, err;

    always #5 clk = ~clk;

    eu_speriph_plug_arbiter #(
        .NB_PLUGS(2), .ID_WIDTH(5), .MAX_OUTSTANDING(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .slv_req_i(slv_req), .slv_add_i(slv_add), .slv_wen_i(slv_wen),
        .slv_wdata_i(slv_wdata), .slv_be_i(slv_be), .slv_id_i(slv_id),
        .slv_gnt_o(slv_gnt), .slv_r_valid_o(slv_r_valid),
        .slv_r_rdata_o(slv_r_rdata), .slv_r_opc_o(slv_r_opc),
        .slv_r_id_o(slv_r_id),
        .mst_req_o(mst_req), .mst_add_o(mst_add), .mst_wen_o(mst_wen),
        .mst_wdata_o(mst_wdata), .mst_be_o(mst_be), .mst_id_o(mst_id),
        .mst_gnt_i(mst_gnt), .mst_r_valid_i(mst_r_valid),
        .mst_r_rdata_i(mst_r_rdata), .mst_r_opc_i(mst_r_opc),
        .mst_r_id_i(mst_r_id),
        .busy_o(busy), .err_o(err)
    );

    typedef struct {
        logic             rst;
        logic [1:0]       req;
        logic             gnt;
        logic             rv;
        logic [1:0][31:0] add, wdata;
        logic [1:0]       wen;
        logic [1:0][3:0]  be;
        logic [1:0][4:0]  id;
        logic [31:0]      rdata;
        logic             opc;
        logic [4:0]       rid;
    } drv_t;

    typedef struct {
        string       nm;
        logic [1:0]  gnt, rv;
        logic        req, busy, err;
        bit          chkf;
        logic [31:0] add, wdata;
        logic        wen;
        logic [3:0]  be;
        logic [4:0]  id;
        bit          chkr;
        logic [31:0] rdata;
        logic        opc;
        logic [4:0]  rid;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic drv_t idle();
        drv_t d;
        d.rst      = 1'b1;
        d.req      = 2'b00;
        d.gnt      = 1'b0;
        d.rv       = 1'b0;
        d.add[0]   = 32'h0000_0100;
        d.add[1]   = 32'h0000_0104;
        d.wdata[0] = 32'hAAAA_0000;
        d.wdata[1] = 32'h5555_0000;
        d.wen      = 2'b11;
        d.be[0]    = 4'h3;
        d.be[1]    = 4'hC;
        d.id[0]    = 5'd1;
        d.id[1]    = 5'd2;
        d.rdata    = 32'h0;
        d.opc      = 1'b0;
        d.rid      = 5'd0;
        return d;
    endfunction

    function automatic exp_t ex(string nm, logic [1:0] g, logic [1:0] rv,
                                logic rq, logic b, logic e);
        exp_t x;
        x.nm = nm; x.gnt = g; x.rv = rv; x.req = rq; x.busy = b; x.err = e;
        x.chkf = 1'b0; x.add = '0; x.wdata = '0; x.wen = 1'b0;
        x.be = '0; x.id = '0;
        x.chkr = 1'b0; x.rdata = '0; x.opc = 1'b0; x.rid = '0;
        return x;
    endfunction

    task automatic cyc(input drv_t d, input exp_t e);
        @(posedge clk);
        #1;
        rst_n       = d.rst;
        slv_req     = d.req;
        slv_add     = d.add;
        slv_wdata   = d.wdata;
        slv_wen     = d.wen;
        slv_be      = d.be;
        slv_id      = d.id;
        mst_gnt     = d.gnt;
        mst_r_valid = d.rv;
        mst_r_rdata = d.rdata;
        mst_r_opc   = d.opc;
        mst_r_id    = d.rid;
        q.push_back(e);
    endtask

    task automatic chk(string nm, string f, logic [31:0] act, logic [31:0] exv);
        checks++;
        if (act !== exv) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, f, act, exv);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.nm, "gnt", 32'(slv_gnt), 32'(e.gnt));
            chk(e.nm, "r_valid", 32'(slv_r_valid), 32'(e.rv));
            chk(e.nm, "mst_req", 32'(mst_req), 32'(e.req));
            chk(e.nm, "busy", 32'(busy), 32'(e.busy));
            chk(e.nm, "err", 32'(err), 32'(e.err));
            if (e.chkf) begin
                chk(e.nm, "add", mst_add, e.add);
                chk(e.nm, "wdata", mst_wdata, e.wdata);
                chk(e.nm, "wen", 32'(mst_wen), 32'(e.wen));
                chk(e.nm, "be", 32'(mst_be), 32'(e.be));
                chk(e.nm, "id", 32'(mst_id), 32'(e.id));
            end
            if (e.chkr) begin
                chk(e.nm, "rdata", slv_r_rdata, e.rdata);
                chk(e.nm, "opc", 32'(slv_r_opc), 32'(e.opc));
                chk(e.nm, "rid", 32'(slv_r_id), 32'(e.rid));
            end
        end
    end

    initial begin
        drv_t d;
        exp_t e;
        logic [1:0] eg, erv;

        rst_n = 1'b0; slv_req = '0; slv_add = '0; slv_wdata = '0;
        slv_wen = '0; slv_be = '0; slv_id = '0; mst_gnt = 1'b0;
        mst_r_valid = 1'b0; mst_r_rdata = '0; mst_r_opc = 1'b0;
        mst_r_id = '0;

        // reset state
        d = idle(); d.rst = 1'b0;
        e = ex("rst", 2'b00, 2'b00, 0, 0, 0);
        e.chkf = 1'b1;
        cyc(d, e);
        d = idle();
        e = ex("idle", 2'b00, 2'b00, 0, 0, 0);
        e.chkf = 1'b1;
        cyc(d, e);

        // both plugs request every cycle, response one cycle later
        for (int k = 0; k < 4; k++) begin
            d = idle(); d.req = 2'b11; d.gnt = 1'b1; d.rv = (k > 0);
`ifdef EU_PLUG_ARB_ROUND_ROBIN_EN
            eg  = (k % 2 == 0) ? 2'b01 : 2'b10;
            erv = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
`else
            eg  = 2'b01;
            erv = (k == 0) ? 2'b00 : 2'b01;
`endif
            e = ex($sformatf("alt%0d", k), eg, erv, 1, k > 0, 0);
            cyc(d, e);
        end
        d = idle(); d.rv = 1'b1;
`ifdef EU_PLUG_ARB_ROUND_ROBIN_EN
        erv = 2'b10;
`else
        erv = 2'b01;
`endif
        cyc(d, ex("alt4", 2'b00, erv, 0, 1, 0));
        cyc(idle(), ex("alt5", 2'b00, 2'b00, 0, 0, 0));

        // lock: plug 1 waits, plug 0 joins, plug 1 keeps the port
        d = idle(); d.req = 2'b10;
        cyc(d, ex("lock1", 2'b00, 2'b00, 1, 0, 0));
        d.req = 2'b11;
        cyc(d, ex("lock2", 2'b00, 2'b00, 1, 0, 0));
        cyc(d, ex("lock3", 2'b00, 2'b00, 1, 0, 0));
        d.gnt = 1'b1;
        cyc(d, ex("lock4", 2'b10, 2'b00, 1, 0, 0));
        d.rv = 1'b1;
        cyc(d, ex("lock5", 2'b01, 2'b10, 1, 1, 0));
        d = idle(); d.rv = 1'b1;
        cyc(d, ex("lock6", 2'b00, 2'b01, 0, 1, 0));
        cyc(idle(), ex("lock7", 2'b00, 2'b00, 0, 0, 0));

        // owner FIFO full stalls the request path
        d = idle(); d.req = 2'b01; d.gnt = 1'b1;
        cyc(d, ex("full1", 2'b01, 2'b00, 1, 0, 0));
        cyc(d, ex("full2", 2'b01, 2'b00, 1, 1, 0));
        e = ex("full3", 2'b00, 2'b00, 0, 1, 0);
        e.chkf = 1'b1;
        cyc(d, e);
        d.rv = 1'b1;
        cyc(d, ex("full4", 2'b00, 2'b01, 0, 1, 0));
        d.rv = 1'b0;
        cyc(d, ex("full5", 2'b01, 2'b00, 1, 1, 0));
        d = idle(); d.rv = 1'b1;
        cyc(d, ex("full6", 2'b00, 2'b01, 0, 1, 0));
        cyc(d, ex("full7", 2'b00, 2'b01, 0, 1, 0));
        cyc(idle(), ex("full8", 2'b00, 2'b00, 0, 0, 0));

        // plug 1 write carries its fields untouched
        d = idle(); d.req = 2'b10; d.gnt = 1'b1;
        d.add[1] = 32'h0000_0204; d.wdata[1] = 32'h5;
        d.be[1] = 4'hF; d.id[1] = 5'd3; d.wen = 2'b01;
        e = ex("wr", 2'b10, 2'b00, 1, 0, 0);
        e.chkf = 1'b1; e.add = 32'h0000_0204; e.wdata = 32'h5;
        e.wen = 1'b0; e.be = 4'hF; e.id = 5'd3;
        cyc(d, e);
        d = idle(); d.rv = 1'b1; d.rdata = 32'h1234_5678;
        d.opc = 1'b1; d.rid = 5'd3;
        e = ex("wr_rsp", 2'b00, 2'b10, 0, 1, 0);
        e.chkr = 1'b1; e.rdata = 32'h1234_5678; e.opc = 1'b1; e.rid = 5'd3;
        cyc(d, e);

        // orphan response sets sticky error
        d = idle(); d.rv = 1'b1; d.rdata = 32'hCAFE_0001;
        e = ex("orph", 2'b00, 2'b00, 0, 0, 0);
        e.chkr = 1'b1; e.rdata = 32'hCAFE_0001;
        cyc(d, e);
        cyc(idle(), ex("orph_err1", 2'b00, 2'b00, 0, 0, 1));
        cyc(idle(), ex("orph_err2", 2'b00, 2'b00, 0, 0, 1));
        d = idle(); d.rst = 1'b0;
        cyc(d, ex("err_clr", 2'b00, 2'b00, 0, 0, 0));

        // reset with one grant outstanding
        d = idle(); d.req = 2'b01; d.gnt = 1'b1;
        cyc(d, ex("mid_gnt", 2'b01, 2'b00, 1, 0, 0));
        cyc(idle(), ex("mid_busy", 2'b00, 2'b00, 0, 1, 0));
        d = idle(); d.rst = 1'b0;
        cyc(d, ex("mid_rst", 2'b00, 2'b00, 0, 0, 0));
        d = idle(); d.rv = 1'b1;
        cyc(d, ex("late_rsp", 2'b00, 2'b00, 0, 0, 0));
        cyc(idle(), ex("late_err", 2'b00, 2'b00, 0, 0, 1));

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
